uart_rx_controller: RTL and testbench

Receive side of the team's UART link: recovers 8-N-1 frames (one low start bit, 8 data bits LSB first, one high stop bit) from an asynchronous serial line. The block oversamples at CLKS_PER_BIT clocks per bit and synchronizes the line. It samples each bit at mid-bit and presents each byte with a one-cycle valid pulse. It flags frames with a bad stop bit. It sits between the pad and the byte consumer, mirroring the transmit controller.

---
 rtl/uart_rx_controller.sv | 148 ++++++++++++++
 tb/tb_uart_rx_controller.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_controller.sv
// 8-N-1 UART receiver: two-flop synchronizer, mid-bit sampling, one-cycle valid/frame-error pulses.
// Define UART_RX_MAJORITY_EN to decide each bit by a 2-of-3 vote over the last three synchronized samples.
module uart_rx_controller #(
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       rx_serial,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_frame_err,
  output logic       rx_active
);

  localparam logic [15:0] HALF = 16'((CLKS_PER_BIT - 1) / 2);
  localparam logic [15:0] LAST = 16'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_HIGH = 3'd4
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] clk_cnt_q, clk_cnt_d;
  logic [2:0]  bit_idx_q, bit_idx_d;
  logic [7:0]  shift_q, shift_d;
  logic [7:0]  data_q, data_d;
  logic        valid_q, valid_d;
  logic        err_q, err_d;
  logic        s1_q, rx_sync_q;
  logic        sample;
  logic [15:0] clk_cnt_inc;

  // Both stages reset high so a reset never looks like a start bit.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_q      <= 1'b1;
      rx_sync_q <= 1'b1;
    end else begin
      s1_q      <= rx_serial;
      rx_sync_q <= s1_q;
    end
  end

`ifdef UART_RX_MAJORITY_EN
  // hist_q[0] mirrors rx_sync_q; [1] and [2] are the two previous cycles.
  logic [2:0] hist_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) hist_q <= 3'b111;
    else          hist_q <= {hist_q[1:0], s1_q};
  end

  assign sample = (hist_q[0] & hist_q[1]) | (hist_q[0] & hist_q[2]) | (hist_q[1] & hist_q[2]);
`else
  assign sample = rx_sync_q;
`endif

  assign clk_cnt_inc = clk_cnt_q + 16'd1;

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves one unassigned (which would infer a latch).
    state_d   = state_q;
    clk_cnt_d = clk_cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    data_d    = data_q;
    valid_d   = 1'b0;
    err_d     = 1'b0;
    unique case (state_q)
      IDLE: begin
        clk_cnt_d = '0;
        bit_idx_d = '0;
        if (!rx_sync_q) state_d = START;
      end
      START: begin
        // The decision lands on the edge where the count reaches HALF.
        if (clk_cnt_inc == HALF) begin
          clk_cnt_d = '0;
          state_d   = sample ? IDLE : DATA;
        end else begin
          clk_cnt_d = clk_cnt_inc;
        end
      end
      DATA: begin
        if (clk_cnt_q == LAST) begin
          clk_cnt_d          = '0;
          shift_d[bit_idx_q] = sample;
          bit_idx_d          = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) state_d = STOP;
        end else begin
          clk_cnt_d = clk_cnt_inc;
        end
      end
      STOP: begin
        if (clk_cnt_q == LAST) begin
          clk_cnt_d = '0;
          if (sample) begin
            data_d  = shift_q;
            valid_d = 1'b1;
            state_d = IDLE;
          end else begin
            err_d   = 1'b1;
            state_d = WAIT_HIGH;
          end
        end else begin
          clk_cnt_d = clk_cnt_inc;
        end
      end
      WAIT_HIGH: begin
        // A held-low break reports once, then waits here for the line to recover.
        clk_cnt_d = '0;
        if (rx_sync_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state is updated with non-blocking assignments so all flops see pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      clk_cnt_q <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      clk_cnt_q <= clk_cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      err_q     <= err_d;
    end
  end

  assign rx_data      = data_q;
  assign rx_valid     = valid_q;
  assign rx_frame_err = err_q;
  assign rx_active    = (state_q == START) || (state_q == DATA) || (state_q == STOP);

endmodule

// File: tb/tb_uart_rx_controller.sv
// Directed bench for uart_rx_controller at 16 clk/bit: timing, back-to-back, false start,
// framing error/break, mid-frame reset and a single-cycle glitch on a data bit.
module tb_uart_rx_controller;

  localparam int CPB = 16;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       rx_serial;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_frame_err;
  logic       rx_active;

  int         cyc = 0;
  int         checks = 0;
  int         failures = 0;
  int         vq[$];
  logic [7:0] dq[$];
  int         eq[$];
  int         e0, e1;

  uart_rx_controller #(.CLKS_PER_BIT(CPB)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .rx_serial    (rx_serial),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_frame_err (rx_frame_err),
    .rx_active    (rx_active)
  );

  always #5 clk = ~clk;

  // cyc equals the number of the most recent rising edge.
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rx_valid) begin
      vq.push_back(cyc);
      dq.push_back(rx_data);
    end
    if (rx_frame_err) eq.push_back(cyc);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Hold the line at v for n rising edges; returns 1 time unit after the last one.
  task automatic drive_bit(input logic v, input int n);
    rx_serial = v;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_v, output int edge0);
    edge0 = cyc + 1;
    drive_bit(1'b0, CPB);
    for (int i = 0; i < 8; i++) drive_bit(d[i], CPB);
    drive_bit(stop_v, CPB);
  endtask

  task automatic clear_logs();
    vq.delete();
    dq.delete();
    eq.delete();
  endtask

  initial begin
    rx_serial = 1'b1;
    reset_n   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_data", rx_data, 8'h00);
    check("rst_valid", rx_valid, 1'b0);
    check("rst_err", rx_frame_err, 1'b0);
    check("rst_active", rx_active, 1'b0);
    reset_n = 1'b1;
    drive_bit(1'b1, 10);

    // Single frame 0xA5.
    clear_logs();
    send_frame(8'hA5, 1'b1, e0);
    check("a5_nvalid", vq.size(), 1);
    check("a5_edge", vq[0] - e0, 153);
    check("a5_data", dq[0], 8'hA5);
    check("a5_nerr", eq.size(), 0);
    check("a5_hold", rx_data, 8'hA5);
    check("a5_idle", rx_active, 1'b0);

    // Back-to-back 0x00 then 0xFF.
    drive_bit(1'b1, 10);
    clear_logs();
    send_frame(8'h00, 1'b1, e0);
    send_frame(8'hFF, 1'b1, e1);
    check("b2b_nvalid", vq.size(), 2);
    check("b2b_edge0", vq[0] - e0, 153);
    check("b2b_gap", vq[1] - vq[0], 160);
    check("b2b_data0", dq[0], 8'h00);
    check("b2b_data1", dq[1], 8'hFF);
    check("b2b_nerr", eq.size(), 0);

    // Three-cycle low glitch on an idle line.
    drive_bit(1'b1, 10);
    clear_logs();
    drive_bit(1'b0, 2);
    check("fs_act_e1", rx_active, 1'b0);
    drive_bit(1'b0, 1);
    check("fs_act_e2", rx_active, 1'b1);
    drive_bit(1'b1, 6);
    check("fs_act_e8", rx_active, 1'b1);
    drive_bit(1'b1, 1);
    check("fs_act_e9", rx_active, 1'b0);
    drive_bit(1'b1, 200);
    check("fs_nvalid", vq.size(), 0);
    check("fs_nerr", eq.size(), 0);

    // Bad stop bit followed by a 40-cycle break, then a good frame.
    drive_bit(1'b1, 10);
    clear_logs();
    send_frame(8'h3C, 1'b0, e0);
    drive_bit(1'b0, 40);
    check("fe_nerr", eq.size(), 1);
    check("fe_edge", eq[0] - e0, 153);
    check("fe_nvalid", vq.size(), 0);
    check("fe_data_kept", rx_data, 8'hFF);
    check("fe_wait_inactive", rx_active, 1'b0);
    drive_bit(1'b1, 10);
    check("fe_nerr_after", eq.size(), 1);
    clear_logs();
    send_frame(8'h3C, 1'b1, e0);
    check("fe_rec_nvalid", vq.size(), 1);
    check("fe_rec_data", dq[0], 8'h3C);
    check("fe_rec_nerr", eq.size(), 0);

    // Reset at edge 60 of frame 0xF3; remaining bits 4..7 and stop are high.
    drive_bit(1'b1, 10);
    clear_logs();
    drive_bit(1'b0, CPB);
    drive_bit(1'b1, CPB);
    drive_bit(1'b1, CPB);
    drive_bit(1'b0, 13);
    check("mr_active_pre", rx_active, 1'b1);
    reset_n = 1'b0;
    #1;
    check("mr_active", rx_active, 1'b0);
    check("mr_data", rx_data, 8'h00);
    check("mr_valid", rx_valid, 1'b0);
    check("mr_err", rx_frame_err, 1'b0);
    drive_bit(1'b0, 3);
    drive_bit(1'b0, CPB);
    drive_bit(1'b1, 4);
    reset_n = 1'b1;
    drive_bit(1'b1, 76);
    drive_bit(1'b1, 20);
    check("mr_nvalid", vq.size(), 0);
    check("mr_nerr", eq.size(), 0);
    check("mr_idle", rx_active, 1'b0);
    clear_logs();
    send_frame(8'h81, 1'b1, e0);
    check("mr_rec_nvalid", vq.size(), 1);
    check("mr_rec_edge", vq[0] - e0, 153);
    check("mr_rec_data", dq[0], 8'h81);

    // Frame 0x00 with a one-cycle high glitch seen by the bit-3 decision (edge 73).
    drive_bit(1'b1, 10);
    clear_logs();
    e0 = cyc + 1;
    drive_bit(1'b0, 71);
    drive_bit(1'b1, 1);
    drive_bit(1'b0, 8);
    drive_bit(1'b0, 4 * CPB);
    drive_bit(1'b1, CPB);
    check("gl_nvalid", vq.size(), 1);
    check("gl_edge", vq[0] - e0, 153);
`ifdef UART_RX_MAJORITY_EN
    check("gl_data", dq[0], 8'h00);
`else
    check("gl_data", dq[0], 8'h08);
`endif
    check("gl_nerr", eq.size(), 0);

    drive_bit(1'b1, 10);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
